// File: rtl/prescaler0_ctrl_pkg.sv
// Shared constants and GTCCR types for the prescaler0 controller.
// Holds the I/O address, GTCCR bit map and counter width.
package prescaler0_ctrl_pkg;

  localparam int         P_CNT_WIDTH = 10;
  localparam logic [5:0] P_GTCCR_ADR = 6'h23;

  localparam int TSM_BIT     = 7;
  localparam int PSRASY_BIT  = 1;
  localparam int PSRSYNC_BIT = 0;

  typedef struct packed {
    logic tsm;
    logic psrasy;
    logic psrsync;
  } gtccr_t;

  function automatic logic [7:0] gtccr_rd(
    input gtccr_t r
  );
    logic [7:0] v;
    v              = 8'h00;
    v[TSM_BIT]     = r.tsm;
    v[PSRASY_BIT]  = r.psrasy;
    v[PSRSYNC_BIT] = r.psrsync;
    return v;
  endfunction

endpackage

// File: rtl/prescaler_counter.sv
// Shared prescaler counter with /8 /64 /256 /1024 enable decode.
// Ports: clk, rst_n, clr_i, en_i in; clk8en_o..clk1024en_o out.
module prescaler_counter
  import prescaler0_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic clk8en_o,
  output logic clk64en_o,
  output logic clk256en_o,
  output logic clk1024en_o
);

  logic [P_CNT_WIDTH-1:0] cnt_q;
  logic [P_CNT_WIDTH-1:0] cnt_d;
  logic                   run;

  assign run = en_i & ~clr_i;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr_i: cnt_d = '0;
      run:   cnt_d = cnt_q + P_CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign clk8en_o    = run & (&cnt_q[2:0]);
  assign clk64en_o   = run & (&cnt_q[5:0]);
  assign clk256en_o  = run & (&cnt_q[7:0]);
  assign clk1024en_o = run & (&cnt_q[9:0]);

endmodule

// File: rtl/prescaler0_ctrl.sv
// Prescaler0 controller: GTCCR register, reset/halt sequencing.
// Ports: I/O bus (io_adr/iowe/iore/dbus), presc_en, clkNen, pulses.
module prescaler0_ctrl
  import prescaler0_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [5:0] io_adr,
  input  logic       iowe,
  input  logic       iore,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       out_en,
  input  logic       presc_en,
  output logic       clk8en,
  output logic       clk64en,
  output logic       clk256en,
  output logic       clk1024en,
  output logic       psr_hold,
  output logic       psrasy_pulse,
  output logic       tsm_release
);

  gtccr_t gt_q;
  gtccr_t gt_d;
  logic   asy_dly_q;
  logic   rel_q;
  logic   rel_d;
  logic   sel;
  logic   wr;
  logic   unused_dbus;

  assign unused_dbus = ^dbus_in[6:2];

  assign sel    = (io_adr == P_GTCCR_ADR);
  assign wr     = iowe & sel;
  assign out_en = iore & sel;

  // Reset bits survive only while the post-write TSM is 1;
  // with TSM 0 a freshly set bit lives exactly one cycle.
  always_comb begin
    gt_d  = gt_q;
    rel_d = 1'b0;
    if (wr) begin
      gt_d.tsm = dbus_in[TSM_BIT];
      rel_d    = gt_q.tsm & ~dbus_in[TSM_BIT];
    end
    gt_d.psrsync = (wr & dbus_in[PSRSYNC_BIT])
                 | (gt_d.tsm & gt_q.psrsync);
    gt_d.psrasy  = (wr & dbus_in[PSRASY_BIT])
                 | (gt_d.tsm & gt_q.psrasy);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gt_q      <= '0;
      asy_dly_q <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      gt_q      <= gt_d;
      asy_dly_q <= gt_q.psrasy;
      rel_q     <= rel_d;
    end
  end

  assign psr_hold     = gt_q.psrsync;
  assign psrasy_pulse = gt_q.psrasy & ~asy_dly_q;
  assign tsm_release  = rel_q;
  assign dbus_out     = out_en ? gtccr_rd(gt_q) : 8'h00;

  prescaler_counter u_cnt (
    .clk         (clk),
    .rst_n       (nrst),
    .clr_i       (gt_q.psrsync),
    .en_i        (presc_en),
    .clk8en_o    (clk8en),
    .clk64en_o   (clk64en),
    .clk256en_o  (clk256en),
    .clk1024en_o (clk1024en)
  );

endmodule
